// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults and helpers for the 3x3 convolution engine
package conv_pkg;

   localparam int DEF_IMG_W   = 640;
   localparam int DEF_IMG_H   = 480;
   localparam int DEF_NCH     = 3;
   localparam int DEF_CH_BITS = 4;
   localparam int DEF_KW      = 5;
   localparam int SUM_W       = DEF_CH_BITS + DEF_KW + 4;

   // Helpers work on fixed maximum widths so any KW/CH_BITS up to 16 fits.
   localparam int MAX_W      = 16;
   localparam int COEF_VEC_W = 9 * MAX_W;

   // Extract tap idx of a packed kernel and sign-extend it to MAX_W bits.
   function automatic logic signed [MAX_W-1:0] coef_at(input logic [COEF_VEC_W-1:0] vec,
                                                       input int idx, input int kw);
      logic signed [MAX_W-1:0] r;
      for (int b = 0; b < MAX_W; b++)
         r[b] = (b < kw) ? vec[idx*kw + b] : vec[idx*kw + kw - 1];
      return r;
   endfunction

   // Saturate a signed value into the unsigned channel range [0, 2^ch_bits-1].
   function automatic logic [MAX_W-1:0] clamp_ch(input int v, input int ch_bits);
      int hi;
      hi = (1 << ch_bits) - 1;
      if (v < 0)
         return '0;
      else if (v > hi)
         return MAX_W'(hi);
      else
         return MAX_W'(v);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - enable-gated delay line of DEPTH accepted samples
module line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ptr;

   // The slot about to be overwritten holds the sample from DEPTH enables ago.
   assign dout = mem[ptr];

   // Write the new sample over the oldest one and advance the circular pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (en) begin
         mem[ptr] <= din;
         ptr      <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 multi-channel convolution with clamp/abs output
module conv3x3_stream import conv_pkg::*; #(
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int NCH     = DEF_NCH,
   parameter int CH_BITS = DEF_CH_BITS,
   parameter int KW      = DEF_KW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [NCH*CH_BITS-1:0] in_pix,
   input  logic [9*KW-1:0]        coef,
   input  logic [3:0]             shift,
   input  logic                   abs_mode,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic [NCH*CH_BITS-1:0] out_pix
);

   localparam int PW    = NCH * CH_BITS;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int PRW   = CH_BITS + 1 + KW;
   localparam int ACC_W = CH_BITS + KW + 4;

   logic [XW-1:0]         x_q, pos_x;
   logic [YW-1:0]         y_q, pos_y;
   logic [9*KW-1:0]       coef_q;
   logic [3:0]            shift_q;
   logic                  abs_q;
   logic [COEF_VEC_W-1:0] coef_ext;
   logic [PW-1:0]         lb0_out, lb1_out;
   logic [PW-1:0]         win [3][3];
   logic                  win_valid, win_sof;
   logic                  s1_valid, s1_sof, s1_abs;
   logic [3:0]            s1_shift;
   logic [PW-1:0]         out_d;

   // A start-of-frame pixel is (0,0) no matter where the counters were.
   assign pos_x    = in_sof ? '0 : x_q;
   assign pos_y    = in_sof ? '0 : y_q;
   assign coef_ext = COEF_VEC_W'(coef_q);

   // Raster position of the next accepted pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (in_valid) begin
         if (pos_x == XW'(IMG_W - 1)) begin
            x_q <= '0;
            y_q <= (pos_y == YW'(IMG_H - 1)) ? '0 : pos_y + YW'(1);
         end else begin
            x_q <= pos_x + XW'(1);
            y_q <= pos_y;
         end
      end
   end

   // Frame configuration is latched on the start-of-frame pixel and held all frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coef_q  <= '0;
         shift_q <= '0;
         abs_q   <= 1'b0;
      end else if (in_valid && in_sof) begin
         coef_q  <= coef;
         shift_q <= shift;
         abs_q   <= abs_mode;
      end
   end

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb0 (
      .clk   (clk),
      .reset (reset),
      .en    (in_valid),
      .din   (in_pix),
      .dout  (lb0_out)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
      .clk   (clk),
      .reset (reset),
      .en    (in_valid),
      .din   (lb0_out),
      .dout  (lb1_out)
   );

   // Window shifts left; row 0 is two lines back, column 0 is two pixels back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else if (in_valid) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1_out;
         win[1][2] <= lb0_out;
         win[2][2] <= in_pix;
      end
   end

   // Stage 0 valid: the window just loaded is fully inside the current frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_valid <= 1'b0;
         win_sof   <= 1'b0;
      end else begin
         win_valid <= in_valid && (pos_y >= YW'(2)) && (pos_x >= XW'(2));
         win_sof   <= in_valid && (pos_y == YW'(2)) && (pos_x == XW'(2));
      end
   end

   // Stage 1 control; shift/abs travel with the data so a new frame cannot alter old results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_sof    <= 1'b0;
         s1_shift  <= '0;
         s1_abs    <= 1'b0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
      end else begin
         s1_valid  <= win_valid;
         s1_sof    <= win_sof;
         s1_shift  <= shift_q;
         s1_abs    <= abs_q;
         out_valid <= s1_valid;
         out_sof   <= s1_sof;
      end
   end

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      logic signed [PRW-1:0]   prod_d [9];
      logic signed [PRW-1:0]   prod_q [9];
      logic signed [ACC_W-1:0] acc, shifted, mag;
      logic [MAX_W-1:0]        cl;

      // Nine products of zero-extended channel value and signed tap.
      always_comb begin : p_prod
         logic signed [CH_BITS:0]  pix_s;
         logic signed [MAX_W-1:0]  kc;
         for (int t = 0; t < 9; t++) begin
            pix_s     = signed'({1'b0, win[t/3][t%3][ch*CH_BITS +: CH_BITS]});
            kc        = coef_at(coef_ext, t, KW);
            prod_d[t] = PRW'(pix_s) * PRW'(kc);
         end
      end

      // Stage 1 register: products.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int t = 0; t < 9; t++)
               prod_q[t] <= '0;
         end else begin
            for (int t = 0; t < 9; t++)
               prod_q[t] <= prod_d[t];
         end
      end

      // Sum wide enough never to overflow, then shift, optional magnitude and clamp.
      always_comb begin
         acc = '0;
         for (int t = 0; t < 9; t++)
            acc = acc + ACC_W'(prod_q[t]);
         shifted = acc >>> s1_shift;
         mag     = (s1_abs && shifted[ACC_W-1]) ? -shifted : shifted;
         cl      = clamp_ch(32'(mag), CH_BITS);
      end

      assign out_d[ch*CH_BITS +: CH_BITS] = cl[CH_BITS-1:0];
   end

   // Stage 2 register: packed clamped result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         out_pix <= '0;
      else
         out_pix <= out_d;
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - randomized self-checking bench for conv3x3_stream
module tb_conv3x3_stream;

   localparam int W    = 8;
   localparam int H    = 6;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [11:0] in_pix = '0;
   logic [44:0] coef = '0;
   logic [3:0]  shift = '0;
   logic        abs_mode = 1'b0;
   logic        out_valid, out_sof;
   logic [11:0] out_pix;

   always #5 clk = ~clk;

   conv3x3_stream #(.IMG_W(W), .IMG_H(H), .NCH(3), .CH_BITS(4), .KW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pix    (in_pix),
      .coef      (coef),
      .shift     (shift),
      .abs_mode  (abs_mode),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_pix   (out_pix)
   );

   typedef struct {
      logic [11:0] pix;
      logic        sof;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] img [H][W];
   logic [11:0] src [NPIX];
   int kern [9];
   int mk [9];
   int shift_v, abs_v, msh, mab, mx, my;
   int total = 0, bad = 0, cyc = 0;
   int out_cnt = 0, sof_cnt = 0, sof_cyc = 0, acc22_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Direct 3x3 convolution of the model image centred on (cy,cx).
   function automatic logic [11:0] ref_pix(input int cy, input int cx);
      logic [11:0] res;
      int s;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         s = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               s += mk[r*3+c] * int'(img[cy-1+r][cx-1+c][4*ch +: 4]);
         s = s >>> msh;
         if (mab != 0 && s < 0) s = -s;
         if (s < 0) s = 0;
         if (s > 15) s = 15;
         res[4*ch +: 4] = 4'(s);
      end
      return res;
   endfunction

   task automatic model_accept(input logic [11:0] p, input logic s);
      if (s) begin
         mx = 0; my = 0;
         mk = kern; msh = shift_v; mab = abs_v;
      end
      if (mx == 2 && my == 2) acc22_cyc = cyc;
      img[my][mx] = p;
      if (my >= 2 && mx >= 2)
         exp_q.push_back('{ref_pix(my-1, mx-1), (my == 2 && mx == 2)});
      mx++;
      if (mx == W) begin
         mx = 0;
         my = (my == H-1) ? 0 : my + 1;
      end
   endtask

   // kind: 0 Laplacian, 1 identity, 2 random
   task automatic set_kernel(input int kind, input int sh, input int ab);
      for (int i = 0; i < 9; i++) begin
         case (kind)
            0: kern[i] = (i == 4) ? 8 : -1;
            1: kern[i] = (i == 4) ? 1 : 0;
            default: kern[i] = int'($urandom_range(0, 31)) - 16;
         endcase
         coef[i*5 +: 5] = 5'(kern[i]);
      end
      shift_v = sh; abs_v = ab;
      shift = 4'(sh);
      abs_mode = ab[0];
   endtask

   // kind: 0 constant 0x555, 1 ramp, 2 single 0xFFF at (3,3), 3 random
   task automatic fill(input int kind);
      for (int i = 0; i < NPIX; i++) begin
         case (kind)
            0: src[i] = 12'h555;
            1: src[i] = 12'(i*73 + 5);
            2: src[i] = (i == 3*W + 3) ? 12'hFFF : 12'h000;
            default: src[i] = 12'($urandom);
         endcase
      end
   endtask

   task automatic send(input int n, input int gmax);
      int g;
      for (int i = 0; i < n; i++) begin
         g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
         repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0; in_sof = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_sof   = (i == 0);
         in_pix   = src[i];
         model_accept(src[i], (i == 0));
      end
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic drain_check(input string tag, input int want_out, input int want_sof);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      repeat (4) @(negedge clk);
      check({tag, "_count"}, out_cnt, want_out);
      check({tag, "_sofs"}, sof_cnt, want_sof);
      out_cnt = 0; sof_cnt = 0;
   endtask

   // Output scoreboard.
   always @(negedge clk) begin
      if (out_valid) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_pix), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("out_pix", 32'(out_pix), 32'(e.pix));
            check("out_sof", 32'(out_sof), 32'(e.sof));
         end
         out_cnt++;
         if (out_sof) begin
            sof_cnt++;
            sof_cyc = cyc;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 9; i++) mk[i] = 0;
      msh = 0; mab = 0; mx = 0; my = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_sof", 32'(out_sof), 0);
      check("rst_pix", 32'(out_pix), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      set_kernel(0, 0, 0); fill(0); send(NPIX, 0);
      drain_check("lap_const", 24, 1);

      set_kernel(1, 0, 0); fill(1); send(NPIX, 0);
      drain_check("ident_ramp", 24, 1);
      check("latency", sof_cyc - acc22_cyc, 3);

      set_kernel(0, 0, 0); fill(2); send(NPIX, 0);
      drain_check("single_clamp", 24, 1);
      set_kernel(0, 0, 1); fill(2); send(NPIX, 0);
      drain_check("single_abs", 24, 1);

      set_kernel(1, 0, 0); fill(1); send(NPIX, 3);
      drain_check("ident_gaps", 24, 1);

      for (int f = 0; f < 4; f++) begin
         set_kernel(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
         fill(3); send(NPIX, 2);
         drain_check("rand_frame", 24, 1);
      end

      set_kernel(0, 0, 1); fill(3); send(3*W + 4, 0);
      set_kernel(2, 1, 0); fill(3); send(NPIX, 0);
      drain_check("mid_sof", 8 + 24, 2);

      set_kernel(2, 0, 1); fill(3); send(30, 0);
      @(posedge clk);
      #2;
      check("pre_rst_valid", 32'(out_valid), 1);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_pix", 32'(out_pix), 0);
      check("mid_rst_sof", 32'(out_sof), 0);
      exp_q.delete();
      mx = 0; my = 0;
      for (int i = 0; i < 9; i++) mk[i] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      out_cnt = 0; sof_cnt = 0;
      @(negedge clk);
      set_kernel(2, 1, 1); fill(3); send(NPIX, 1);
      drain_check("after_rst", 24, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 convolution engine for packed multi-channel pixels (RGB444 by default), the parametrised successor to the fixed edge-detect window. It sits between the pixel source and the display/frame-store path. Image size, channel count/width and coefficient width are parameters. The kernel, the output scaling and the clamp/absolute-value mode are run-time inputs latched per frame. Input is a valid-qualified stream with start-of-frame marking, and the output carries its own valid and start-of-frame.

## Interface
- IMG_W, 640, pixels per line (≥4)
- IMG_H, 480, lines per frame (≥3)
- NCH, 3, channels per pixel
- CH_BITS, 4, bits per channel; channel 0 occupies the LSBs
- KW, 5, signed two's-complement coefficient width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; low clears all state
- in_valid  in  1  in_pix accepted at this edge; gaps allowed anywhere
- in_sof  in  1  qualifies in_pix as pixel (0,0) of a frame
- in_pix  in  NCH*CH_BITS  packed input pixel
- coef  in  9*KW  kernel k[r][c] at bits [(3r+c)*KW +: KW]; r=0 is the oldest line
- shift  in  4  arithmetic right-shift applied to each channel sum
- abs_mode  in  1  0 = clamp negatives to 0, 1 = take magnitude before the upper clamp
- out_valid  out  1  out_pix valid this cycle
- out_sof  out  1  first output of a frame
- out_pix  out  NCH*CH_BITS  packed result

## Operation
- Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) advance only on accepted pixels. x wraps to 0 and increments y. y wraps to 0 after the last pixel.
- An accepted pixel with in_sof forces position (0,0), whatever the counter values. This includes a mid-frame in_sof: the frame restarts and no output is produced until new-frame windows are valid.
- coef, shift and abs_mode are captured on the accepted in_sof pixel and held for the whole frame. Before the first in_sof after reset, the kernel is all zero.
- Two line buffers, each IMG_W deep, advance only on accepted pixels. They feed a 3x3 window register array that shifts left on each accepted pixel.
- A window is valid when the accepted pixel has y≥2 and x≥2. It is centred on (y-1, x-1). Only interior pixels are produced: exactly (IMG_W-2)*(IMG_H-2) outputs per frame, in raster order.
- Per-channel arithmetic:
  - each pixel channel is zero-extended to CH_BITS+1 bits and multiplied by its signed coefficient;
  - the nine products are summed at width CH_BITS+KW+4, so nothing overflows;
  - the sum is arithmetic-shifted right by shift;
  - if abs_mode=1, the magnitude is taken;
  - the result is clamped to [0, 2^CH_BITS-1].
- out_sof is asserted with the output centred on (1,1).
- There is no backpressure, and the downstream block must accept every out_valid.

## Timing
- Reset values: out_valid=0, out_sof=0, out_pix=0. Counters, window, line buffers, coefficient register and pipeline valids are all 0.
- Pipeline has three registered stages:
  - edge E: in_valid is sampled and the window is updated;
  - edge E+1: products are registered;
  - edge E+2: sum, shift and clamp are registered into out_pix.
- out_valid goes high in the cycle after edge E+2, for one cycle per valid window.
- The pipeline advances every clock, and stalls do not hold outputs. Input gaps therefore produce output gaps but never change the values or their order.
- Back-to-back in_valid gives one output per cycle in the steady state.
- Reset asserted mid-frame clears everything immediately. In-flight results are dropped and out_valid drops to 0 asynchronously.
- If in_sof arrives while results are in flight, the results already in the pipeline still emerge. New-frame outputs begin at the earliest when the new (2,2) pixel is accepted.

## Structure
- Shared package `conv_pkg`:
  - default IMG_W, IMG_H, NCH, CH_BITS, KW;
  - localparam SUM_W = CH_BITS+KW+4;
  - coefficient-unpack and clamp functions.
- Sub-module `line_buffer` (DEPTH, WIDTH): enable-gated delay line, synchronous RAM or register array, with the same active-low asynchronous reset on its control and valid state. Instantiated twice.
- The top level holds the counters, window, frame-capture registers and the three-stage arithmetic pipeline, with one generate loop per channel.

## Test plan
- IMG_W=8, IMG_H=6, constant pixel 0x555, Laplacian kernel (centre 8, others -1), shift 0 → exactly 24 outputs, all 0x000. out_sof only on the first output.
- Identity kernel (centre 1, others 0), raster-ramp image, continuous valid → out_pix equals the interior input pixel. The first output appears three edges after accepting pixel (2,2).
- Single 0xFFF pixel at (3,3) on a zero background, Laplacian kernel:
  - abs_mode=0 → 0xFFF at (3,3) and 0x000 at its 8 neighbours;
  - abs_mode=1 → 0xFFF at the neighbours as well.
- Same identity stream with random 0–3 cycle in_valid gaps → the output sequence is identical to the gap-free run.
- in_sof reasserted at (3,4) with a new kernel → the old frame's outputs stop, the counters restart, and the new frame yields 24 outputs using the new kernel.
- reset pulled low mid-frame → outputs are 0 immediately. After release and a fresh in_sof frame, results are correct.
